mc6809_phase_gen: RTL and testbench

- Parametrised successor to the fixed MC6809 clock-enable logic.
- Derives the CPU quadrature bus phases (Q, E) from a programmable fractional-N divider of the system clock.
- Emits single-cycle cen_Q/cen_E enables for the mc6809i core, plus E/Q levels for bus peripherals.
- Implements MRDY cycle stretching with a bounded stretch limit.
- Sits between the system clock domain and mc6809i, replacing hard-wired cen logic.

---
 rtl/mc6809_phase_gen.sv | 176 +++++++++++++++++
 tb/tb_mc6809_phase_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc6809_phase_gen.sv
// ---------------------------------------------------------------------------
// mc6809_phase_gen
//
// Generates the MC6809 quadrature bus phases (Q leads E by a quarter cycle)
// from a fractional-N divider of the system clock. It emits single-clk
// enables for the mc6809i core and registered E/Q levels for bus peripherals.
// It also supports MRDY cycle stretching with a bounded stretch length.
//
// Parameters:
//   W            divider numerator/denominator/accumulator width
//   MAX_STRETCH  maximum base ticks an E-high phase may be held by MRDY
//   SW           stretch counter width (2**SW > MAX_STRETCH)
//
// Ports:
//   clk          system clock, rising edge
//   nRESET       synchronous active-low reset
//   cen_in       global advance enable (0 freezes divider and phase)
//   num, den     divider ratio: num base ticks per den enabled clks
//   MRDY         memory ready, sampled only on P3 ticks
//   cen_Q        one-clk pulse when leaving P2 (Q falling)
//   cen_E        one-clk pulse when leaving P3 (E falling)
//   E, Q         bus phase levels
//   stretching   high while P3 is being held by MRDY
//   stretch_to   one-clk pulse when a stretch is cut off at MAX_STRETCH
// ---------------------------------------------------------------------------
module mc6809_phase_gen #(
    parameter int unsigned W           = 10,
    parameter int unsigned MAX_STRETCH = 10,
    parameter int unsigned SW          = 4
) (
    input  logic         clk,
    input  logic         nRESET,
    input  logic         cen_in,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    input  logic         MRDY,
    output logic         cen_Q,
    output logic         cen_E,
    output logic         E,
    output logic         Q,
    output logic         stretching,
    output logic         stretch_to
);

    typedef enum logic [1:0] {
        P0 = 2'd0,   // Q=0 E=0
        P1 = 2'd1,   // Q=1 E=0
        P2 = 2'd2,   // Q=1 E=1
        P3 = 2'd3    // Q=0 E=1
    } phase_e;

    localparam logic [SW-1:0] MAX_CNT = SW'(MAX_STRETCH);

    // State registers
    phase_e        phase_q, phase_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [SW-1:0] cnt_q, cnt_d;

    // Registered outputs
    logic cen_q_q, cen_q_d;
    logic cen_e_q, cen_e_d;
    logic e_q, e_d;
    logic q_q, q_d;
    logic str_q, str_d;
    logic sto_q, sto_d;

    // Divider
    logic         tick;
    logic [W:0]   sum;
    logic [W:0]   rem;
    logic [W:0]   den_x;

    always_comb begin
        den_x = {1'b0, den};
        sum   = {1'b0, acc_q} + {1'b0, num};
        rem   = sum - den_x;
        tick  = 1'b0;
        acc_d = acc_q;
        if (cen_in) begin
            if ((den == '0) || (num >= den)) begin
                // Ratio >= 1: tick every enabled clk, accumulator parked at 0.
                tick  = 1'b1;
                acc_d = '0;
            end else if (sum >= den_x) begin
                tick = 1'b1;
                // A runtime reduction of den can leave the remainder still
                // out of range; dropping it avoids a burst of back-to-back
                // catch-up ticks.
                if (rem >= den_x) begin
                    acc_d = '0;
                end else begin
                    acc_d = rem[W-1:0];
                end
            end else begin
                acc_d = sum[W-1:0];
            end
        end
    end

    // Phase FSM next state and pulse decisions
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        cen_q_d = 1'b0;
        cen_e_d = 1'b0;
        sto_d   = 1'b0;

        if (tick) begin
            case (phase_q)
                P0: phase_d = P1;
                P1: phase_d = P2;
                P2: begin
                    phase_d = P3;
                    cen_q_d = 1'b1;
                end
                P3: begin
                    if (MRDY) begin
                        phase_d = P0;
                        cen_e_d = 1'b1;
                    end else if (cnt_q < MAX_CNT) begin
                        cnt_d = cnt_q + SW'(1);
                    end else begin
                        phase_d = P0;
                        cen_e_d = 1'b1;
                        sto_d   = 1'b1;
                    end
                end
                default: phase_d = P0;
            endcase
        end

        if (phase_d == P0) begin
            cnt_d = '0;
        end

        // A non-zero count in P3 means at least one tick has been held.
        str_d = (phase_d == P3) && (cnt_d != '0);

        // Levels trail the phase register by one clk so that each enable
        // pulse lands in the last clk of its level's high time.
        q_d = (phase_q == P1) || (phase_q == P2);
        e_d = (phase_q == P2) || (phase_q == P3);
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            phase_q <= P0;
            acc_q   <= '0;
            cnt_q   <= '0;
            cen_q_q <= 1'b0;
            cen_e_q <= 1'b0;
            e_q     <= 1'b0;
            q_q     <= 1'b0;
            str_q   <= 1'b0;
            sto_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            cen_q_q <= cen_q_d;
            cen_e_q <= cen_e_d;
            e_q     <= e_d;
            q_q     <= q_d;
            str_q   <= str_d;
            sto_q   <= sto_d;
        end
    end

    assign cen_Q      = cen_q_q;
    assign cen_E      = cen_e_q;
    assign E          = e_q;
    assign Q          = q_q;
    assign stretching = str_q;
    assign stretch_to = sto_q;

endmodule

// File: tb/tb_mc6809_phase_gen.sv
// ---------------------------------------------------------------------------
// tb_mc6809_phase_gen
//
// Self-checking bench for mc6809_phase_gen: a table of per-clk vectors
// {inputs, expected outputs} plus directed sequences for divider accuracy,
// enable freeze, reset mid-stretch and runtime den reduction.
// ---------------------------------------------------------------------------
module tb_mc6809_phase_gen;

    logic       clk;
    logic       nRESET;
    logic       cen_in;
    logic [9:0] num;
    logic [9:0] den;
    logic       MRDY;
    logic       cen_Q;
    logic       cen_E;
    logic       E;
    logic       Q;
    logic       stretching;
    logic       stretch_to;

    mc6809_phase_gen #(
        .W           (10),
        .MAX_STRETCH (10),
        .SW          (4)
    ) dut (
        .clk        (clk),
        .nRESET     (nRESET),
        .cen_in     (cen_in),
        .num        (num),
        .den        (den),
        .MRDY       (MRDY),
        .cen_Q      (cen_Q),
        .cen_E      (cen_E),
        .E          (E),
        .Q          (Q),
        .stretching (stretching),
        .stretch_to (stretch_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bits: {cen_Q, cen_E, E, Q, stretching, stretch_to}
    localparam logic [5:0] O_IDLE = 6'b00_00_00;
    localparam logic [5:0] O_Q    = 6'b00_01_00;
    localparam logic [5:0] O_QE_C = 6'b10_11_00;
    localparam logic [5:0] O_E_C  = 6'b01_10_00;
    localparam logic [5:0] O_E_ST = 6'b00_10_10;
    localparam logic [5:0] O_E_TO = 6'b01_10_01;
    localparam logic [5:0] O_QE   = 6'b00_11_00;

    typedef struct {
        logic       nrst;
        logic       cen;
        logic [9:0] n;
        logic [9:0] d;
        logic       mrdy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    function automatic logic [5:0] outs();
        return {cen_Q, cen_E, E, Q, stretching, stretch_to};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic nr, input logic c, input logic [9:0] n,
                       input logic [9:0] d, input logic m, input logic [5:0] e);
        vec_t v;
        v.nrst = nr; v.cen = c; v.n = n; v.d = d; v.mrdy = m; v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive inputs away from the active edge, then sample 1 time unit after it.
    task automatic drive(input logic nr, input logic c, input logic [9:0] n,
                         input logic [9:0] d, input logic m);
        @(negedge clk);
        nRESET = nr; cen_in = c; num = n; den = d; MRDY = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned tick_cnt;
        int unsigned cq_cnt;
        int unsigned ce_cnt;
        int unsigned consec;
        int unsigned acc_bad;
        logic        prev_tick;

        nRESET = 1'b0; cen_in = 1'b0; num = '0; den = '0; MRDY = 1'b1;

        // ---------------- vector table ----------------
        add(0, 1, 1, 1, 1, O_IDLE);
        add(0, 1, 1, 1, 1, O_IDLE);
        // Basic period-4 cycle
        for (int i = 0; i < 2; i++) begin
            add(1, 1, 1, 1, 1, O_IDLE);
            add(1, 1, 1, 1, 1, O_Q);
            add(1, 1, 1, 1, 1, O_QE_C);
            add(1, 1, 1, 1, 1, O_E_C);
        end
        // 3-tick stretch; MRDY low outside P3 is ignored
        add(1, 1, 1, 1, 1, O_IDLE);
        add(1, 1, 1, 1, 0, O_Q);
        add(1, 1, 1, 1, 0, O_QE_C);
        for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, O_E_ST);
        add(1, 1, 1, 1, 1, O_E_C);
        // Stretch cut off at MAX_STRETCH
        add(1, 1, 1, 1, 0, O_IDLE);
        add(1, 1, 1, 1, 0, O_Q);
        add(1, 1, 1, 1, 0, O_QE_C);
        for (int i = 0; i < 10; i++) add(1, 1, 1, 1, 0, O_E_ST);
        add(1, 1, 1, 1, 0, O_E_TO);
        // Next bus cycle runs normally
        add(1, 1, 1, 1, 1, O_IDLE);
        add(1, 1, 1, 1, 1, O_Q);
        add(1, 1, 1, 1, 1, O_QE_C);
        add(1, 1, 1, 1, 1, O_E_C);
        // Reset dominates a disabled cen_in
        add(0, 0, 1, 1, 1, O_IDLE);
        // den == 0 ticks every clk
        add(1, 1, 5, 0, 1, O_IDLE);
        add(1, 1, 5, 0, 1, O_Q);
        add(1, 1, 5, 0, 1, O_QE_C);
        add(1, 1, 5, 0, 1, O_E_C);
        // num == 0 never ticks
        add(0, 1, 0, 5, 1, O_IDLE);
        for (int i = 0; i < 4; i++) add(1, 1, 0, 5, 1, O_IDLE);
        // num > den saturates to one tick per clk
        add(0, 1, 7, 3, 1, O_IDLE);
        add(1, 1, 7, 3, 1, O_IDLE);
        add(1, 1, 7, 3, 1, O_Q);
        add(1, 1, 7, 3, 1, O_QE_C);
        add(1, 1, 7, 3, 1, O_E_C);

        foreach (vecs[i]) begin
            drive(vecs[i].nrst, vecs[i].cen, vecs[i].n, vecs[i].d, vecs[i].mrdy);
            chk($sformatf("vec%0d {cQ,cE,E,Q,st,to}", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // ---------------- divider 3/8 over 64 clks ----------------
        drive(0, 1, 3, 8, 1);
        tick_cnt = 0; cq_cnt = 0; ce_cnt = 0; consec = 0; acc_bad = 0;
        prev_tick = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            nRESET = 1'b1; cen_in = 1'b1; num = 10'd3; den = 10'd8; MRDY = 1'b1;
            #1;
            if (dut.tick) tick_cnt++;
            if (dut.tick && prev_tick) consec++;
            if (dut.acc_q >= 10'd8) acc_bad++;
            prev_tick = dut.tick;
            @(posedge clk);
            #1;
            if (cen_Q) cq_cnt++;
            if (cen_E) ce_cnt++;
        end
        chk("div38 ticks", tick_cnt, 24);
        chk("div38 cen_E", ce_cnt, 6);
        chk("div38 cen_Q", cq_cnt, 6);
        chk("div38 consecutive ticks", consec, 0);
        chk("div38 acc range", acc_bad, 0);

        // ---------------- cen_in freeze mid-P2 ----------------
        drive(0, 1, 1, 1, 1);
        drive(1, 1, 1, 1, 1);
        drive(1, 1, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 1, 1);
            chk($sformatf("freeze clk%0d", i), 32'(outs()), 32'(O_QE));
        end
        drive(1, 1, 1, 1, 1);
        chk("freeze resume", 32'(outs()), 32'(O_QE_C));

        drive(0, 1, 3, 8, 1);
        drive(1, 1, 3, 8, 1);
        for (int i = 0; i < 3; i++) drive(1, 0, 3, 8, 1);
        chk("freeze acc held", 32'(dut.acc_q), 3);
        drive(1, 1, 3, 8, 1);
        chk("freeze acc resumes", 32'(dut.acc_q), 6);

        // ---------------- reset mid-stretch ----------------
        drive(0, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, 1, 1, 1, 0);
        chk("midstretch stretching", 32'(stretching), 1);
        drive(0, 1, 1, 1, 0);
        chk("midstretch reset outs", 32'(outs()), 32'(O_IDLE));
        chk("midstretch reset phase", 32'(dut.phase_q), 0);
        chk("midstretch reset acc", 32'(dut.acc_q), 0);

        // ---------------- den reduced 8 -> 2 with acc = 6 ----------------
        drive(0, 1, 1, 8, 1);
        for (int i = 0; i < 6; i++) drive(1, 1, 1, 8, 1);
        chk("denchg acc before", 32'(dut.acc_q), 6);
        chk("denchg no ticks yet", 32'(outs()), 32'(O_IDLE));
        @(negedge clk);
        den = 10'd2;
        #1;
        chk("denchg tick", 32'(dut.tick), 1);
        @(posedge clk);
        #1;
        chk("denchg acc cleared", 32'(dut.acc_q), 0);
        drive(1, 1, 1, 2, 1);
        chk("denchg advanced to P1", 32'(outs()), 32'(O_Q));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
